imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory loader for the RV32i SoC. Accepts a framed byte stream (magic, word count, little-endian words, XOR checksum) over a valid/ready byte interface and writes each assembled 32-bit word into the instruction memory write port. It holds the core in reset until the image is loaded and verified. It is the producer side of the imem contents that the core fetches and the bench monitors.

## Interface
- ADDR_WIDTH, 10: imem word-address width; capacity is 2**ADDR_WIDTH words.
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- rx_valid_i  input  1  byte available on rx_data_i.
- rx_data_i  input  8  stream byte.
- rx_ready_o  output  1  loader accepts a byte this cycle.
- imem_we_o  output  1  one-cycle imem write strobe.
- imem_addr_o  output  ADDR_WIDTH  imem word address.
- imem_wdata_o  output  32  imem write data.
- core_resetn_o  output  1  active-low reset to the core; low until load succeeds.
- done_o  output  1  image loaded and checksum matched (sticky).
- error_o  output  1  framing/length/checksum error (sticky).

## Operation
- Frame layout: 0xA5 magic, LEN_LO, LEN_HI (N, 16-bit word count), then 4·N data bytes (each word LSB first), then CSUM. CSUM is the 8-bit XOR of the 4·N data bytes only. N=0 → expected CSUM 0x00.
- A byte is accepted on a rising edge where rx_valid_i & rx_ready_o are both high.
- FSM states are IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
  - IDLE: accepted 0xA5 → LEN0. Any other byte is discarded and the FSM stays in IDLE.
  - LEN0 → LEN1 on accept; the byte becomes N[7:0].
  - LEN1, on accept (the byte is N[15:8]):
    - N > 2**ADDR_WIDTH → ERROR.
    - N == 0 → CSUM.
    - otherwise → DATA.
  - DATA: byte counter 0..3 places each byte into word bits [8k+7:8k] and folds it into the running XOR. On the 4th byte:
    - issue the write (see Timing) and increment the word index.
    - if the word index reaches N → CSUM.
  - CSUM: accepted byte equals the running XOR → DONE, otherwise → ERROR.
  - DONE and ERROR are terminal until reset_i.
- rx_ready_o = 1 in IDLE, LEN0, LEN1, DATA, CSUM; 0 in DONE and ERROR. It is decoded from state only and never depends on rx_valid_i.
- The word index starts at 0 and counts to N−1 at most; it never wraps, because the N limit is enforced in LEN1.
- core_resetn_o = 1 only in DONE. In ERROR the core stays in reset.

## Timing
- Reset values: FSM=IDLE; rx_ready_o=1; imem_we_o=0; imem_addr_o=0; imem_wdata_o=0; core_resetn_o=0; done_o=0; error_o=0. The byte counter, word index, length and XOR are all 0.
- reset_i asserted at any point, including mid-frame, clears everything at once (asynchronous). The partial image is abandoned and is not rolled back.
- imem_we_o, imem_addr_o and imem_wdata_o are registered. imem_we_o is high for exactly the one cycle after the edge that accepts a word's 4th byte. Address and data are valid in that same cycle and hold until the next write.
- Back-to-back bytes (rx_valid_i held high) are accepted every cycle. Maximum write rate is one write per 4 cycles.
- done_o and core_resetn_o rise in the cycle after the matching CSUM byte is accepted. error_o rises in the cycle after the offending byte is accepted.
- Gaps (rx_valid_i low) stall the FSM with no state change.

## Structure
- Shared package `rv32i_loader_pkg` holds:
  - the `loader_state_t` enum (IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR);
  - `LOADER_MAGIC = 8'hA5`.
- Single module with no sub-module: one state register, a 2-bit byte counter, a 16-bit length register, an ADDR_WIDTH+1-bit word index, a 32-bit assembly register and an 8-bit XOR register.
- At SoC level, core_resetn_o is ANDed with the board resetn before it reaches the core.

## Test plan
- Nominal load, ADDR_WIDTH=10:
  - stimulus: A5 02 00 13 00 00 00 6F 00 00 00 7C sent back-to-back;
  - required: a write of 0x00000013 @0, then a write of 0x0000006F @1, 4 cycles apart; then done_o=1, core_resetn_o=1, rx_ready_o=0.
- Junk and gaps:
  - stimulus: 00 FF 13 before A5, and rx_valid_i deasserted for 3 cycles mid-word;
  - required: junk ignored, same two writes as the nominal case, done_o=1.
- Bad checksum:
  - stimulus: nominal frame with CSUM 7D;
  - required: both writes occur, then error_o=1, done_o=0, core_resetn_o stays 0.
- Oversize:
  - stimulus: A5 01 04 (N=1025);
  - required: no writes, error_o=1 the cycle after 04 is accepted, rx_ready_o=0.
- Empty image:
  - stimulus: A5 00 00 00;
  - required: no imem_we_o pulses, done_o=1, core_resetn_o=1.
- Reset mid-load:
  - stimulus: reset_i pulsed after A5 02 00 13 00, then a full nominal frame;
  - required: all outputs return to reset values immediately; the second frame yields writes @0 and @1 and done_o=1.

Source files
------------

// File: rtl/rv32i_loader_pkg.sv
// Shared types and constants for the boot-time imem loader.
package rv32i_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 16;

  localparam logic [BYTE_W-1:0] LOADER_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } loader_state_t;

  // States in which the loader is still consuming stream bytes.
  function automatic logic loader_accepting(input loader_state_t s);
    return (s == IDLE) || (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream loader: assembles LE words into imem, verifies an XOR
// checksum and releases the core from reset once the image is good.
module imem_loader
  import rv32i_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  rx_valid_i,
  input  logic [BYTE_W-1:0]     rx_data_i,
  output logic                  rx_ready_o,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [WORD_W-1:0]     imem_wdata_o,
  output logic                  core_resetn_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int unsigned IDX_W    = ADDR_WIDTH + 1;
  localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;

  loader_state_t         state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [IDX_W-1:0]      widx_q, widx_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [BYTE_W-1:0]     xor_q, xor_d;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  core_resetn_q, core_resetn_d;

  logic                  accept;
  logic [LEN_W-1:0]      n_rx;

  assign accept = rx_valid_i & ready_q;
  assign n_rx   = {rx_data_i, len_q[BYTE_W-1:0]};

  // State, datapath and registered outputs; async reset abandons any partial load.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      byte_cnt_q    <= 2'd0;
      len_q         <= '0;
      widx_q        <= '0;
      word_q        <= '0;
      xor_q         <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      core_resetn_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      len_q         <= len_d;
      widx_q        <= widx_d;
      word_q        <= word_d;
      xor_q         <= xor_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      error_q       <= error_d;
      core_resetn_q <= core_resetn_d;
    end
  end

  // Next-state, word assembly, checksum fold and output decode.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    widx_d     = widx_q;
    word_d     = word_q;
    xor_d      = xor_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      IDLE: begin
        if (accept && (rx_data_i == LOADER_MAGIC)) begin
          state_d = LEN0;
        end
      end

      LEN0: begin
        if (accept) begin
          len_d   = {8'h00, rx_data_i};
          state_d = LEN1;
        end
      end

      LEN1: begin
        if (accept) begin
          len_d      = n_rx;
          byte_cnt_d = 2'd0;
          widx_d     = '0;
          xor_d      = '0;
          if (32'(n_rx) > CAPACITY) begin
            state_d = ERROR;
          end else if (n_rx == '0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          word_d[{byte_cnt_q, 3'b000} +: BYTE_W] = rx_data_i;
          xor_d      = xor_q ^ rx_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_WIDTH-1:0];
            wdata_d = word_d;
            widx_d  = widx_q + IDX_W'(1);
            if (LEN_W'(widx_d) == len_q) begin
              state_d = CSUM;
            end
          end
        end
      end

      CSUM: begin
        if (accept) begin
          state_d = (rx_data_i == xor_q) ? DONE : ERROR;
        end
      end

      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase

    ready_d       = loader_accepting(state_d);
    done_d        = (state_d == DONE);
    error_d       = (state_d == ERROR);
    core_resetn_d = (state_d == DONE);
  end

  assign rx_ready_o    = ready_q;
  assign imem_we_o     = we_q;
  assign imem_addr_o   = addr_q;
  assign imem_wdata_o  = wdata_q;
  assign core_resetn_o = core_resetn_q;
  assign done_o        = done_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames against a stream-parsing reference model.
module tb_imem_loader;

  localparam int unsigned AW  = 10;
  localparam int unsigned CAP = 1 << AW;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          rx_valid_i = 1'b0;
  logic [7:0]    rx_data_i = 8'h00;
  logic          rx_ready_o;
  logic          imem_we_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;
  logic          core_resetn_o;
  logic          done_o;
  logic          error_o;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .rx_valid_i    (rx_valid_i),
    .rx_data_i     (rx_data_i),
    .rx_ready_o    (rx_ready_o),
    .imem_we_o     (imem_we_o),
    .imem_addr_o   (imem_addr_o),
    .imem_wdata_o  (imem_wdata_o),
    .core_resetn_o (core_resetn_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [7:0]  stream[$];
  logic [31:0] gen_w[$];
  logic [31:0] exp_w[$];
  bit          exp_done;
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(posedge clk_i) cycle <= cycle + 1;

  // Record every write strobe seen mid-cycle.
  always @(negedge clk_i) begin
    if (imem_we_o === 1'b1) begin
      wr_addr.push_back(int'(imem_addr_o));
      wr_data.push_back(imem_wdata_o);
      wr_cyc.push_back(cycle);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic apply_reset();
    rx_valid_i = 1'b0;
    reset_i    = 1'b1;
    #2;
    check("rst_rx_ready", 32'(rx_ready_o), 32'd1);
    check("rst_we", 32'(imem_we_o), 32'd0);
    check("rst_addr", 32'(imem_addr_o), 32'd0);
    check("rst_wdata", imem_wdata_o, 32'd0);
    check("rst_core_resetn", 32'(core_resetn_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    tick();
    reset_i = 1'b0;
    clear_log();
  endtask

  // Frame from gen_w with optional junk prefix and corrupted checksum.
  task automatic build_frame(input int njunk, input bit corrupt);
    logic [7:0] b;
    logic [7:0] x;
    stream.delete();
    for (int i = 0; i < njunk; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      stream.push_back(b);
    end
    stream.push_back(8'hA5);
    stream.push_back(8'(gen_w.size()));
    stream.push_back(8'(gen_w.size() >> 8));
    x = 8'h00;
    foreach (gen_w[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = gen_w[i][8*k +: 8];
        stream.push_back(b);
        x = x ^ b;
      end
    end
    if (corrupt) x = x ^ 8'($urandom_range(1, 255));
    stream.push_back(x);
  endtask

  // Reference: parse the byte stream by the frame rules.
  task automatic model();
    int p;
    int n;
    logic [7:0] x;
    logic [31:0] w;
    exp_w.delete();
    p = 0;
    while (p < stream.size() && stream[p] != 8'hA5) p++;
    n = int'(stream[p+1]) + 256 * int'(stream[p+2]);
    if (n > int'(CAP)) begin
      exp_done = 1'b0;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        w = w | (32'(stream[p + 3 + 4*i + k]) << (8*k));
        x = x ^ stream[p + 3 + 4*i + k];
      end
      exp_w.push_back(w);
    end
    exp_done = (stream[p + 3 + 4*n] == x);
  endtask

  task automatic drive(input int gap_pct, input int gap_at, input int gap_len);
    for (int i = 0; i < stream.size(); i++) begin
      if (i == gap_at) idle(gap_len);
      else if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) idle(int'($urandom_range(1, 3)));
      send(stream[i]);
    end
  endtask

  // Compare end-of-frame status and the write log against the model.
  task automatic verify(input string tag);
    int first_bad;
    model();
    check({tag, "_done"}, 32'(done_o), 32'(exp_done));
    check({tag, "_error"}, 32'(error_o), 32'(!exp_done));
    check({tag, "_core_resetn"}, 32'(core_resetn_o), 32'(exp_done));
    check({tag, "_rx_ready"}, 32'(rx_ready_o), 32'd0);
    check({tag, "_we_idle"}, 32'(imem_we_o), 32'd0);
    check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(exp_w.size()));
    first_bad = -1;
    for (int i = 0; i < exp_w.size() && i < wr_addr.size(); i++) begin
      if (first_bad < 0 && (wr_addr[i] != i || wr_data[i] !== exp_w[i])) first_bad = i;
    end
    check({tag, "_first_bad_write"}, 32'(first_bad), 32'hFFFF_FFFF);
    if (exp_w.size() > 0) begin
      check({tag, "_hold_addr"}, 32'(imem_addr_o), 32'(exp_w.size() - 1));
      check({tag, "_hold_data"}, imem_wdata_o, exp_w[exp_w.size() - 1]);
    end
  endtask

  task automatic nominal_words();
    gen_w.delete();
    gen_w.push_back(32'h0000_0013);
    gen_w.push_back(32'h0000_006F);
  endtask

  initial begin
    tick();
    apply_reset();

    // Nominal back-to-back frame
    nominal_words();
    build_frame(0, 1'b0);
    check("nom_csum_byte", 32'(stream[stream.size()-1]), 32'h7C);
    drive(0, -1, 0);
    verify("nominal");
    if (wr_cyc.size() == 2) check("nom_write_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
    else check("nom_write_log_len", 32'(wr_cyc.size()), 32'd2);
    send(8'hA5);
    check("nom_after_done_sticky", 32'(done_o), 32'd1);
    check("nom_after_done_nowrite", 32'(wr_addr.size()), 32'd2);

    // Junk prefix and a 3-cycle gap mid-word
    apply_reset();
    nominal_words();
    build_frame(0, 1'b0);
    stream.push_front(8'h13);
    stream.push_front(8'hFF);
    stream.push_front(8'h00);
    drive(0, 8, 3);
    verify("junk_gap");

    // Bad checksum
    apply_reset();
    nominal_words();
    build_frame(0, 1'b0);
    stream[stream.size()-1] = 8'h7D;
    drive(0, -1, 0);
    verify("bad_csum");

    // Oversize length
    apply_reset();
    stream.delete();
    stream.push_back(8'hA5);
    stream.push_back(8'h01);
    stream.push_back(8'h04);
    drive(0, -1, 0);
    verify("oversize");

    // Empty image
    apply_reset();
    gen_w.delete();
    build_frame(0, 1'b0);
    drive(0, -1, 0);
    verify("empty");

    // Reset mid-load, then a full frame
    apply_reset();
    nominal_words();
    build_frame(0, 1'b0);
    while (stream.size() > 5) void'(stream.pop_back());
    drive(0, -1, 0);
    apply_reset();
    build_frame(0, 1'b0);
    drive(0, -1, 0);
    verify("reset_mid");

    // Randomized frames
    for (int r = 0; r < 8; r++) begin
      apply_reset();
      gen_w.delete();
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) gen_w.push_back($urandom());
      build_frame(int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
      drive(25, -1, 0);
      verify($sformatf("rand%0d", r));
    end

    // Exactly full capacity
    apply_reset();
    gen_w.delete();
    for (int i = 0; i < int'(CAP); i++) gen_w.push_back($urandom());
    build_frame(0, 1'b0);
    drive(0, -1, 0);
    verify("full_cap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
